// File: rtl/prism_sp_puzzle_fifo_w_arbiter_if.sv
// Write side of the shared puzzle FIFO: one master drives wr_en/wr_data,
// the FIFO reports full.
interface fifo_write_interface #(
    parameter int DATA_WIDTH = 72
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;

    modport master (output wr_en, output wr_data, input full);
    modport slave  (input wr_en, input wr_data, output full);
endinterface

// File: rtl/prism_sp_puzzle_fifo_w_arbiter.sv
// Round-robin arbiter that packs word-serial requester beats into full-width
// entries and writes them into the shared puzzle FIFO.
module prism_sp_puzzle_fifo_w_arbiter #(
    parameter int NREQ     = 4,
    parameter int IN_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*IN_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    fifo_write_interface.master      fifo_w,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);
    localparam int DATA_WIDTH = fifo_w.DATA_WIDTH;
    localparam int NWORDS     = (DATA_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
    localparam int LASTOFF    = (NWORDS - 1) * IN_WIDTH;
    localparam int LASTBITS   = DATA_WIDTH - LASTOFF;
    localparam int IDW        = $clog2(NREQ);
    localparam int CW         = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t                state_r;
    logic [IDW-1:0]        grant_id_r;
    logic [IDW-1:0]        rr_r;
    logic [CW-1:0]         beat_cnt_r;
    logic                  wr_en_r;
    logic [DATA_WIDTH-1:0] wr_data_r;
    logic [IDW-1:0]        pick_s;
    logic [IN_WIDTH-1:0]   req_word_s;
    logic [IN_WIDTH-1:0]   req_words_s [NREQ];

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % NREQ;
        return IDW'(sum);
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_words_s[g] = req_data[g*IN_WIDTH +: IN_WIDTH];
    end

    assign req_word_s     = req_words_s[grant_id_r];
    assign fifo_w.wr_en   = wr_en_r;
    assign fifo_w.wr_data = wr_data_r;
    assign grant_id       = grant_id_r;
    assign busy           = (state_r != IDLE);

    // Round-robin pick: walk downward so the nearest index after rr_r wins.
    always_comb begin
        pick_s = rr_r;
        for (int i = NREQ; i >= 1; i--) begin
            pick_s = req_valid[rr_idx(rr_r, i)] ? rr_idx(rr_r, i) : pick_s;
        end
    end

    // Ready decoded from registered state only, so no valid-to-ready path.
    always_comb begin
        req_ready = '0;
        if (state_r == COLLECT) begin
            req_ready[grant_id_r] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Arbitration, beat packing and FIFO write sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            grant_id_r <= '0;
            rr_r       <= IDW'(NREQ - 1);
            beat_cnt_r <= '0;
            wr_en_r    <= 1'b0;
            wr_data_r  <= '0;
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id_r <= pick_s;
                        beat_cnt_r <= '0;
                        state_r    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (req_valid[grant_id_r]) begin
                        for (int k = 0; k < NWORDS - 1; k++) begin
                            if (beat_cnt_r == CW'(k)) begin
                                wr_data_r[k*IN_WIDTH +: IN_WIDTH] <= req_word_s;
                            end
                        end
                        // Final beat may be partial; surplus input bits are dropped.
                        if (beat_cnt_r == LAST_BEAT) begin
                            wr_data_r[LASTOFF +: LASTBITS] <= req_word_s[LASTBITS-1:0];
                            state_r <= WRITE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + CW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (!fifo_w.full) begin
                        wr_en_r <= 1'b1;
                        rr_r    <= grant_id_r;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prism_sp_puzzle_fifo_w_arbiter.sv
// Directed bench: a 72-bit (3 beat) and a 16-bit (1 beat) build of the
// arbiter, checked against hand-computed entries and cadences.
module tb_prism_sp_puzzle_fifo_w_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid72 = 4'd0;
    logic [127:0] req_data72 = 128'd0;
    logic [3:0]   req_ready72;
    logic [1:0]   grant72;
    logic         busy72;
    logic         full72 = 1'b0;
    logic [3:0]   req_valid16 = 4'd0;
    logic [127:0] req_data16 = 128'd0;
    logic [3:0]   req_ready16;
    logic [1:0]   grant16;
    logic         busy16;
    logic         full16 = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nwr72 = 0, nbeat72 = 0, nwr16 = 0;
    logic [1:0]  wr_gid72 [0:63];
    int          wr_cyc72 [0:63];
    logic [71:0] wr_dat72 [0:63];
    logic [1:0]  wr_gid16 [0:63];
    int          wr_cyc16 [0:63];
    logic [15:0] wr_dat16 [0:63];

    fifo_write_interface #(.DATA_WIDTH(72)) fw72 ();
    fifo_write_interface #(.DATA_WIDTH(16)) fw16 ();
    assign fw72.full = full72;
    assign fw16.full = full16;

    prism_sp_puzzle_fifo_w_arbiter #(.NREQ(4), .IN_WIDTH(32)) u72 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid72), .req_data(req_data72),
        .req_ready(req_ready72), .fifo_w(fw72), .grant_id(grant72), .busy(busy72)
    );
    prism_sp_puzzle_fifo_w_arbiter #(.NREQ(4), .IN_WIDTH(32)) u16 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid16), .req_data(req_data16),
        .req_ready(req_ready16), .fifo_w(fw16), .grant_id(grant16), .busy(busy16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record write pulses and accepted beats mid-cycle.
    always @(negedge clk) begin
        if (fw72.wr_en) begin
            wr_gid72[nwr72 % 64] = grant72;
            wr_cyc72[nwr72 % 64] = cyc;
            wr_dat72[nwr72 % 64] = fw72.wr_data;
            nwr72++;
        end
        if (|(req_valid72 & req_ready72)) nbeat72++;
        if (fw16.wr_en) begin
            wr_gid16[nwr16 % 64] = grant16;
            wr_cyc16[nwr16 % 64] = cyc;
            wr_dat16[nwr16 % 64] = fw16.wr_data;
            nwr16++;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid72 = 4'd0; req_valid16 = 4'd0; full72 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fw72.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %0b expected 0", fw72.wr_en); end
        checks++; if (fw72.wr_data !== 72'd0) begin failures++; $display("FAIL reset_wr_data: got %0h expected 0", fw72.wr_data); end
        checks++; if (grant72 !== 2'd0) begin failures++; $display("FAIL reset_grant: got %0d expected 0", grant72); end
        checks++; if (busy72 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy72); end
        checks++; if (req_ready72 !== 4'd0) begin failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready72); end
        checks++; if (fw16.wr_data !== 16'd0) begin failures++; $display("FAIL reset_wr_data16: got %0h expected 0", fw16.wr_data); end
    endtask

    task automatic test_single();
        int b0, w0;
        b0 = nbeat72; w0 = nwr72;
        req_valid72 = 4'b0100; req_data72[64 +: 32] = 32'h11111111;
        step();
        checks++; if (grant72 !== 2'd2) begin failures++; $display("FAIL single_grant: got %0d expected 2", grant72); end
        checks++; if (req_ready72 !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b expected 0100", req_ready72); end
        checks++; if (busy72 !== 1'b1) begin failures++; $display("FAIL single_busy: got %0b expected 1", busy72); end
        step(); req_data72[64 +: 32] = 32'h22222222;
        step(); req_data72[64 +: 32] = 32'h333333AB;
        step(); req_valid72 = 4'd0;
        checks++; if (req_ready72 !== 4'd0 || fw72.wr_en !== 1'b0) begin failures++; $display("FAIL single_write_state: got ready=%b wr_en=%0b expected 0000/0", req_ready72, fw72.wr_en); end
        step();
        checks++; if (fw72.wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en: got %0b expected 1", fw72.wr_en); end
        checks++; if (fw72.wr_data !== 72'hAB_22222222_11111111) begin failures++; $display("FAIL single_wr_data: got %0h expected ab2222222211111111", fw72.wr_data); end
        step();
        checks++; if (fw72.wr_en !== 1'b0 || busy72 !== 1'b0) begin failures++; $display("FAIL single_after: got wr_en=%0b busy=%0b expected 0/0", fw72.wr_en, busy72); end
        checks++; if (nbeat72 - b0 != 3) begin failures++; $display("FAIL single_beats: got %0d expected 3", nbeat72 - b0); end
        checks++; if (nwr72 - w0 != 1) begin failures++; $display("FAIL single_pulses: got %0d expected 1", nwr72 - w0); end
    endtask

    task automatic test_round_robin();
        int w0, g;
        logic [7:0] b;
        logic [71:0] exp;
        do_reset();
        w0 = nwr72;
        for (int i = 0; i < 4; i++) req_data72[i*32 +: 32] = {4{8'(16 + i)}};
        req_valid72 = 4'b1111;
        for (int k = 0; k < 80 && (nwr72 - w0) < 5; k++) step();
        checks++;
        if (nwr72 - w0 < 5) begin
            failures++; $display("FAIL rr_timeout: got %0d pulses expected 5", nwr72 - w0);
        end else begin
            for (int k = 0; k < 5; k++) begin
                g = k % 4; b = 8'(16 + g); exp = {b, {2{{4{b}}}}};
                checks++; if (wr_gid72[w0 + k] !== 2'(g)) begin failures++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, wr_gid72[w0 + k], g); end
                checks++; if (wr_dat72[w0 + k] !== exp) begin failures++; $display("FAIL rr_data%0d: got %0h expected %0h", k, wr_dat72[w0 + k], exp); end
                if (k > 0) begin
                    checks++; if (wr_cyc72[w0 + k] - wr_cyc72[w0 + k - 1] != 5) begin failures++; $display("FAIL rr_cadence%0d: got %0d expected 5", k, wr_cyc72[w0 + k] - wr_cyc72[w0 + k - 1]); end
                end
            end
        end
        req_valid72 = 4'd0;
    endtask

    task automatic test_full_backpressure();
        int w0;
        do_reset();
        w0 = nwr72;
        full72 = 1'b1;
        req_valid72 = 4'b0001; req_data72[0 +: 32] = 32'hCAFE0001;
        step(); step(); req_data72[0 +: 32] = 32'hCAFE0002;
        step(); req_data72[0 +: 32] = 32'h000000C3;
        step(); req_valid72 = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (fw72.wr_en !== 1'b0 || req_ready72 !== 4'd0 || busy72 !== 1'b1 || fw72.wr_data !== 72'hC3_CAFE0002_CAFE0001) begin
                failures++; $display("FAIL full_hold%0d: got wr_en=%0b ready=%b busy=%0b data=%0h expected 0/0000/1/c3cafe0002cafe0001", i, fw72.wr_en, req_ready72, busy72, fw72.wr_data);
            end
            step();
        end
        full72 = 1'b0;
        step();
        checks++; if (fw72.wr_en !== 1'b1) begin failures++; $display("FAIL full_release_wr_en: got %0b expected 1", fw72.wr_en); end
        checks++; if (fw72.wr_data !== 72'hC3_CAFE0002_CAFE0001) begin failures++; $display("FAIL full_release_data: got %0h expected c3cafe0002cafe0001", fw72.wr_data); end
        step();
        checks++; if (fw72.wr_en !== 1'b0) begin failures++; $display("FAIL full_single_pulse: got %0b expected 0", fw72.wr_en); end
        checks++; if (nwr72 - w0 != 1) begin failures++; $display("FAIL full_pulses: got %0d expected 1", nwr72 - w0); end
        checks++; if (grant72 !== 2'd1) begin failures++; $display("FAIL full_next_grant: got %0d expected 1", grant72); end
        req_valid72 = 4'd0;
    endtask

    task automatic test_stall();
        int b0;
        do_reset();
        b0 = nbeat72;
        req_valid72 = 4'b0010; req_data72[32 +: 32] = 32'h5A5A0000; req_data72[96 +: 32] = 32'hFFFFFFFF;
        step();
        checks++; if (grant72 !== 2'd1) begin failures++; $display("FAIL stall_grant: got %0d expected 1", grant72); end
        step(); req_valid72 = 4'b1000;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (grant72 !== 2'd1 || req_ready72 !== 4'b0010 || busy72 !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d: got grant=%0d ready=%b busy=%0b expected 1/0010/1", i, grant72, req_ready72, busy72);
            end
            step();
        end
        req_valid72 = 4'b1010; req_data72[32 +: 32] = 32'h5A5A0001;
        step(); req_data72[32 +: 32] = 32'hFFFFFF77;
        step(); req_valid72 = 4'b1000;
        step();
        checks++; if (fw72.wr_en !== 1'b1 || fw72.wr_data !== 72'h77_5A5A0001_5A5A0000) begin failures++; $display("FAIL stall_entry: got wr_en=%0b data=%0h expected 1/775a5a00015a5a0000", fw72.wr_en, fw72.wr_data); end
        checks++; if (nbeat72 - b0 != 3) begin failures++; $display("FAIL stall_beats: got %0d expected 3", nbeat72 - b0); end
        step();
        checks++; if (grant72 !== 2'd3) begin failures++; $display("FAIL stall_next_grant: got %0d expected 3", grant72); end
        req_valid72 = 4'd0;
    endtask

    task automatic test_reset_mid();
        int w0;
        do_reset();
        req_valid72 = 4'b0100; req_data72[64 +: 32] = 32'h99999999;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fw72.wr_en !== 1'b0 || busy72 !== 1'b0 || req_ready72 !== 4'd0 || grant72 !== 2'd0 || fw72.wr_data !== 72'd0) begin
            failures++; $display("FAIL async_reset: got wr_en=%0b busy=%0b ready=%b grant=%0d data=%0h expected all 0", fw72.wr_en, busy72, req_ready72, grant72, fw72.wr_data);
        end
        w0 = nwr72;
        req_valid72 = 4'b0101; req_data72[0 +: 32] = 32'h01234567;
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++; if (grant72 !== 2'd0) begin failures++; $display("FAIL post_reset_grant: got %0d expected 0", grant72); end
        repeat (4) step();
        checks++; if (fw72.wr_en !== 1'b1 || fw72.wr_data !== 72'h67_01234567_01234567) begin failures++; $display("FAIL post_reset_entry: got wr_en=%0b data=%0h expected 1/670123456701234567", fw72.wr_en, fw72.wr_data); end
        step();
        checks++; if (nwr72 - w0 != 1) begin failures++; $display("FAIL post_reset_pulses: got %0d expected 1", nwr72 - w0); end
        req_valid72 = 4'd0;
    endtask

    task automatic test_nwords1();
        int w0;
        logic [15:0] exp_d [0:2];
        logic [1:0]  exp_g [0:2];
        exp_d[0] = 16'hBEEF; exp_d[1] = 16'h5678; exp_d[2] = 16'hBEEF;
        exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd0;
        do_reset();
        w0 = nwr16;
        req_data16[0 +: 32] = 32'hDEADBEEF; req_data16[32 +: 32] = 32'h12345678;
        req_valid16 = 4'b0011;
        for (int k = 0; k < 40 && (nwr16 - w0) < 3; k++) step();
        checks++;
        if (nwr16 - w0 < 3) begin
            failures++; $display("FAIL nw1_timeout: got %0d pulses expected 3", nwr16 - w0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (wr_dat16[w0 + k] !== exp_d[k]) begin failures++; $display("FAIL nw1_data%0d: got %0h expected %0h", k, wr_dat16[w0 + k], exp_d[k]); end
                checks++; if (wr_gid16[w0 + k] !== exp_g[k]) begin failures++; $display("FAIL nw1_grant%0d: got %0d expected %0d", k, wr_gid16[w0 + k], exp_g[k]); end
                if (k > 0) begin
                    checks++; if (wr_cyc16[w0 + k] - wr_cyc16[w0 + k - 1] != 3) begin failures++; $display("FAIL nw1_cadence%0d: got %0d expected 3", k, wr_cyc16[w0 + k] - wr_cyc16[w0 + k - 1]); end
                end
            end
        end
        req_valid16 = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_backpressure();
        test_stall();
        test_reset_mid();
        test_nwords1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prism_sp_puzzle_fifo_w_arbiter.md
Name: prism_sp_puzzle_fifo_w_arbiter

Overview:
- Shares one FIFO write port between NREQ word-serial requesters; each requester delivers IN_WIDTH-bit words.
- Grants one requester at a time, round-robin, and holds the grant for a complete FIFO entry (NWORDS beats).
- Packs the beats little-end first into the entry, then issues a single-cycle write when the FIFO is not full.
- Sits between SP-unit producers and a shared puzzle FIFO, and is that FIFO's sole writer.

Parameters:
- NREQ, 4, number of requesters (>=2).
- IN_WIDTH, 32, requester word width in bits.
- Derived, not overridable: DATA_WIDTH = fifo_w.DATA_WIDTH; NWORDS = ceil(DATA_WIDTH/IN_WIDTH); LASTBITS = DATA_WIDTH - (NWORDS-1)*IN_WIDTH.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  bit i: requester i presents a word.
- req_data  input  NREQ*IN_WIDTH  slice i*IN_WIDTH +: IN_WIDTH is requester i's word.
- req_ready  output  NREQ  bit i: word of requester i accepted this cycle if valid.
- fifo_w  interface  fifo_write_interface.master  uses wr_en (out), wr_data (out, DATA_WIDTH), full (in).
- grant_id  output  $clog2(NREQ)  currently or last granted requester.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous, also mid-operation): state=IDLE, beat counter=0, wr_en=0, wr_data=0, grant_id=0, busy=0, req_ready=0, rr pointer=NREQ-1 so requester 0 has top priority. Any partial entry is discarded. No write is issued.
- States: IDLE, COLLECT, WRITE.
- IDLE, any req_valid high:
  - Pick the first valid index searching upward from rr pointer+1, modulo NREQ.
  - Register grant_id; beat counter=0; go to COLLECT.
  - Grant is visible one cycle after req_valid.
- IDLE, no req_valid: stay in IDLE.
- COLLECT:
  - req_ready[grant_id]=1 and all other bits 0 (decoded from registered state, no combinational path from req_valid).
  - On req_valid&req_ready, beat k is written to wr_data[k*IN_WIDTH +: IN_WIDTH]. The last beat (k=NWORDS-1) writes only its low LASTBITS bits; upper input bits are dropped.
  - The counter increments per beat. On accepting beat NWORDS-1, go to WRITE.
  - If the requester drops valid mid-entry, hold state and grant indefinitely; there is no timeout and no preemption.
- WRITE:
  - req_ready all 0.
  - If fifo_w.full=0: wr_en<=1 for exactly one cycle, rr pointer<=grant_id, go to IDLE.
  - If full=1: hold wr_data stable, wr_en=0, stay in WRITE.
  - Registered wr_en is safe because this block is the only writer; full can only deassert while waiting.
- wr_data is unchanged outside COLLECT beats; bits not written in the current entry retain old values (don't-care to the consumer).
- Throughput: NWORDS+2 cycles per entry minimum (1 arbitration, NWORDS beats, 1 write).
- NWORDS=1 (DATA_WIDTH<=IN_WIDTH): one beat, then WRITE.
- A requester whose valid deasserts while another holds the grant loses nothing; requests are level-based.
- rr wrap-around: after granting NREQ-1, the search starts at 0.
- Simultaneous wr_en pulse and new req_valid: wr_en is issued on the IDLE entry cycle and arbitration proceeds in that same IDLE cycle. No entry interleaves with another.

Test Plan:
- Single requester: DATA_WIDTH=72, IN_WIDTH=32, req 2 sends 0x11111111, 0x22222222, 0x333333AB with full=0. Expect one wr_en pulse with wr_data=0xAB_22222222_11111111, grant_id=2, and exactly 3 req_ready beats.
- All 4 requesters continuously valid after reset: grant order 0,1,2,3,0. Each entry takes 5 cycles (NWORDS=3); wr_en pulses exactly every 5 cycles.
- full=1 held for 10 cycles at WRITE: wr_en stays 0, wr_data stable, req_ready all 0. Full drops, and wr_en pulses 1 cycle later, once only.
- Granted requester 1 deasserts valid after beat 0 for 7 cycles while requester 3 is valid: grant stays 1, req_ready[3]=0. The entry completes with requester 1's data.
- rst_n asserted low mid-COLLECT after 2 beats: wr_en, busy and req_ready go 0 immediately (asynchronously). After release, no write of the partial entry occurs and the first grant goes to requester 0 if valid.
- NWORDS=1 build (DATA_WIDTH=16, IN_WIDTH=32): input 0xDEADBEEF produces wr_data=0xBEEF with a 3-cycle per-entry cadence.
